// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg: opcodes, FSM state encoding and command-word width for the ALU issue stage
package alu_issue_pkg;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_SHR = 2'b11;
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, HOLD = 2'd2} state_t;
  function automatic int cmd_w(input int dw);
    return 2 + 2 * dw;
  endfunction
endpackage

// File: rtl/alu_issue_fifo.sv
// alu_issue_fifo: synchronous FIFO (push/pop, full/empty, count) parameterised by W and DEPTH
module alu_issue_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rp];
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
  always_ff @(posedge clk)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop) rp <= rp + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: FIFO-buffered issue stage driving a combinational ALU and registering its result; ALU_ISSUE_ZFLAG_EN adds res_zero
module alu_issue_ctrl
  import alu_issue_pkg::*;
#(
  parameter int DW = 3,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [DW-1:0] cmd_a,
  input  logic [DW-1:0] cmd_b,
  output logic [DW-1:0] alu_din0,
  output logic [DW-1:0] alu_din1,
  output logic [1:0]    alu_sel,
  input  logic [DW-1:0] alu_dout,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [DW-1:0] res_data,
  output logic [1:0]    res_op
`ifdef ALU_ISSUE_ZFLAG_EN
  , output logic        res_zero
`endif
);
  localparam int CW = cmd_w(DW);
  state_t state;
  logic [CW-1:0] head;
  logic full, empty;
  logic [$clog2(DEPTH):0] count;
  logic exec;
  assign exec = state == EXEC;
  assign cmd_ready = !full;
  assign res_valid = state == HOLD;
  alu_issue_fifo #(.W(CW), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(cmd_valid),
    .pop(exec),
    .din({cmd_op, cmd_a, cmd_b}),
    .dout(head),
    .full(full),
    .empty(empty),
    .count(count)
  );
  always_comb begin
    alu_sel = exec ? head[CW-1 -: 2] : '0;
    alu_din0 = exec ? head[2*DW-1 -: DW] : '0;
    alu_din1 = exec ? head[DW-1:0] : '0;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      res_data <= '0;
      res_op <= '0;
`ifdef ALU_ISSUE_ZFLAG_EN
      res_zero <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: state <= empty ? IDLE : EXEC;
        EXEC: begin
          res_data <= alu_dout;
          res_op <= head[CW-1 -: 2];
`ifdef ALU_ISSUE_ZFLAG_EN
          res_zero <= alu_dout == '0;
`endif
          state <= HOLD;
        end
        HOLD: state <= !res_ready ? HOLD : (count == '0 ? IDLE : EXEC);
        default: state <= IDLE;
      endcase
    end
endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Sequential issue stage placed directly upstream of the combinational 3-bit ALU (ADD/SUB/AND/SHR). It accepts operation commands over a valid/ready handshake and buffers them in a small FIFO. It drives the ALU's operand and select inputs one command at a time, registers the ALU result, and presents that result downstream over a second valid/ready handshake.

## Interface
Parameters:
- DW, 3, operand/result width; must match the ALU datapath width.
- DEPTH, 2, command FIFO depth; power of two, at least 2.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO can accept a command.
- cmd_op  in  2  opcode: 00 ADD, 01 SUB, 10 AND, 11 SHR.
- cmd_a  in  DW  operand A.
- cmd_b  in  DW  operand B.
- alu_din0  out  DW  to ALU din0.
- alu_din1  out  DW  to ALU din1.
- alu_sel  out  2  to ALU sel.
- alu_dout  in  DW  from ALU dout; combinational return.
- res_valid  out  1  result held.
- res_ready  in  1  downstream accepts the result.
- res_data  out  DW  registered ALU result.
- res_op  out  2  opcode that produced res_data.

## Operation
- Push: cmd_valid && cmd_ready writes {op, a, b} at the FIFO tail. cmd_ready = (count != DEPTH); it does not depend on cmd_valid.
- FSM states:
  - IDLE. When the FIFO is non-empty, go to EXEC.
  - EXEC. Drive alu_din0/din1/sel from the FIFO head. At the clock edge, capture alu_dout into res_data and head.op into res_op, pop the FIFO, and go to HOLD.
  - HOLD. res_valid = 1. If res_ready && FIFO non-empty, go to EXEC. If res_ready && FIFO empty, go to IDLE. If !res_ready, stay; res_data and res_op stay stable.
- A push and a pop in the same cycle are legal; count is unchanged.
- alu_din0/din1/sel are 0 outside EXEC. This keeps the ALU inputs quiet and makes them deterministic.
- Arithmetic is performed by the ALU, modulo 2^DW, with no carry or borrow. SHR shifts A right by 1 and ignores B.
- FIFO pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.

## Timing
- Reset values: cmd_ready = 1, res_valid = 0, res_data = 0, res_op = 0, alu_* = 0, state = IDLE, FIFO empty.
- Reset mid-operation discards all buffered commands and any held result. The first cycle after rst deasserts is IDLE.
- Latency: a command accepted at edge N, with the FSM idle, gives EXEC in cycle N+1 and res_valid at N+2.
- Throughput: one result per 2 cycles while res_ready is held high.
- With DEPTH = 2, the full case is 2 commands in the FIFO plus 1 result held in HOLD; cmd_ready = 0 in that case.
- The FIFO pops only in EXEC, so cmd_ready rises in the cycle after EXEC.

## Configuration
- ALU_ISSUE_ZFLAG_EN defined:
  - Adds output res_zero (1 bit), registered in EXEC as (alu_dout == 0). It is held with res_data and resets to 0.
- Not defined: the port and its register are absent.

## Structure
- alu_issue_pkg holds:
  - OP_ADD/OP_SUB/OP_AND/OP_SHR localparams.
  - The FSM state encodings: IDLE = 2'd0, EXEC = 2'd1, HOLD = 2'd2.
  - The command-word width constant (2 + 2*DW).
- Sub-module alu_issue_fifo: a synchronous FIFO with push/pop, full/empty and count, parameterised by width and depth. The FSM and result register stay in alu_issue_ctrl.

## Test plan
- ADD a=3, b=2, res_ready=1: in EXEC alu_sel=00, alu_din0=3, alu_din1=2. res_data=5 and res_op=00 at N+2.
- SUB a=2, b=3: res_data=3'b111. With the macro defined, res_zero=0.
- Back-to-back AND a=6, b=3, then SHR a=5, with res_ready=1: results 2 then 2, on res_valid pulses 2 cycles apart.
- Backpressure: res_ready=0, push 3 commands. cmd_ready drops after 2 accepts and res_data stays stable. Raising res_ready drains all 3 results in order.
- Simultaneous push/pop: count is unchanged and no command is lost or duplicated.
- Assert rst while in HOLD with 2 commands queued. The next cycle shows res_valid=0 and cmd_ready=1, and no stale result appears afterwards.
